// File: rtl/core_inst_seq.sv
// core_inst_seq: per-core instruction sequencer driving the 21-bit inst word and registered mem_in
// ports: clk/reset (sync, active-high); start/load_n/read_out start a sequence from IDLE;
// in_data/in_valid/in_ready fill N/V memories; mem_in/inst/out_valid/busy/done are registered,
// in_ready is decoded from state only
module core_inst_seq #(
    parameter int bw          = 8,
    parameter int pr          = 8,
    parameter int col         = 8,
    parameter int total_cycle = 8,
    parameter int drain       = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             load_n,
    input  logic             read_out,
    input  logic [pr*bw-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [pr*bw-1:0] mem_in,
    output logic [20:0]      inst,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);
    typedef enum logic [3:0] {IDLE, NWR, NLD, VWR, EXE, DRN, MOV, PRD, FIN} state_t;
    localparam logic [9:0] NL = 10'(col);
    localparam logic [9:0] TL = 10'(total_cycle);
    localparam logic [9:0] DL = 10'(drain);
    state_t state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic ro_q, ro_d;
    logic [20:0] inst_q, inst_d;
    logic [pr*bw-1:0] mem_q, mem_d;
    logic ov_q, busy_q, done_q;
    logic acc;
    assign in_ready  = (state_q == NWR) || (state_q == VWR);
    assign acc       = in_valid && in_ready;
    assign inst      = inst_q;
    assign mem_in    = mem_q;
    assign out_valid = ov_q;
    assign busy      = busy_q;
    assign done      = done_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ro_d    = ro_q;
        inst_d  = '0;
        mem_d   = mem_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = load_n ? NWR : VWR;
                ro_d    = read_out;
                cnt_d   = '0;
            end
            NWR, VWR: if (acc) begin
                inst_d[15:12] = cnt_q[3:0];
                inst_d[2]     = state_q == NWR;
                inst_d[4]     = state_q == VWR;
                mem_d         = in_data;
                cnt_d         = cnt_q + 10'd1;
                if (cnt_q == (state_q == NWR ? NL : TL) - 10'd1) begin
                    state_d = state_q == NWR ? NLD : EXE;
                    cnt_d   = '0;
                end
            end else begin
                // a stalled fill cycle keeps the last address on the bus
                inst_d[15:12] = inst_q[15:12];
            end
            NLD: begin
                // k=0 primes the array, k=1..col stream N rows, k=col+1 flushes the last row
                inst_d[6] = 1'b1;
                if (cnt_q >= 10'd1 && cnt_q <= NL) begin
                    inst_d[3]     = 1'b1;
                    inst_d[15:12] = 4'(cnt_q - 10'd1);
                end
                cnt_d   = cnt_q == NL + 10'd1 ? '0 : cnt_q + 10'd1;
                state_d = cnt_q == NL + 10'd1 ? VWR : NLD;
            end
            EXE: begin
                inst_d[7]     = 1'b1;
                inst_d[5]     = 1'b1;
                inst_d[15:12] = cnt_q[3:0];
                cnt_d   = cnt_q == TL - 10'd1 ? '0 : cnt_q + 10'd1;
                state_d = cnt_q == TL - 10'd1 ? DRN : EXE;
            end
            DRN: begin
                cnt_d   = cnt_q == DL - 10'd1 ? '0 : cnt_q + 10'd1;
                state_d = cnt_q == DL - 10'd1 ? MOV : DRN;
            end
            MOV: begin
                inst_d[16]   = 1'b1;
                inst_d[0]    = 1'b1;
                inst_d[11:8] = cnt_q[3:0];
                cnt_d   = cnt_q == TL - 10'd1 ? '0 : cnt_q + 10'd1;
                state_d = cnt_q == TL - 10'd1 ? (ro_q ? PRD : FIN) : MOV;
            end
            PRD: begin
                inst_d[1]    = 1'b1;
                inst_d[11:8] = cnt_q[3:0];
                cnt_d   = cnt_q == TL - 10'd1 ? '0 : cnt_q + 10'd1;
                state_d = cnt_q == TL - 10'd1 ? FIN : PRD;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ro_q    <= 1'b0;
            inst_q  <= '0;
            mem_q   <= '0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ro_q    <= ro_d;
            inst_q  <= inst_d;
            mem_q   <= mem_d;
            ov_q    <= inst_q[1];
            busy_q  <= state_d != IDLE;
            done_q  <= state_q == FIN;
        end
    end
endmodule

// File: tb/tb_core_inst_seq.sv
// tb_core_inst_seq: randomized bench checking core_inst_seq against a queue-based phase model
module tb_core_inst_seq;
    localparam int BW = 8, PR = 8, COL = 8, TC = 8, DR = 10;
    logic clk = 1'b0;
    logic reset, start, load_n, read_out, in_valid, in_ready, out_valid, busy, done;
    logic [PR*BW-1:0] in_data, mem_in;
    logic [20:0] inst;
    always #5 clk = ~clk;
    core_inst_seq #(.bw(BW), .pr(PR), .col(COL), .total_cycle(TC), .drain(DR)) dut (
        .clk(clk), .reset(reset), .start(start), .load_n(load_n), .read_out(read_out),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .mem_in(mem_in),
        .inst(inst), .out_valid(out_valid), .busy(busy), .done(done));
    typedef struct {logic [1:0] kind; logic [20:0] w;} slot_t;
    slot_t q[$];
    logic [20:0] e_inst = '0;
    logic [PR*BW-1:0] e_mem = '0;
    logic e_ov = 1'b0, e_done = 1'b0, e_busy = 1'b0, e_rdy = 1'b0;
    int errors = 0, checks = 0, cyc = 0, len = 0, ovc = 0;
    logic [20:0] first;
    bit live = 1'b0;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", n, a, e, cyc);
        end
    endtask
    function automatic logic [20:0] word(input logic [7:0] lo, input int va, input int pa, input logic of);
        return {4'b0, of, 4'(va), 4'(pa), lo};
    endfunction
    task automatic build(input logic ln, input logic ro);
        q.delete();
        if (ln) begin
            for (int i = 0; i < COL; i++) q.push_back('{2'd1, word(8'h04, i, 0, 1'b0)});
            q.push_back('{2'd0, word(8'h40, 0, 0, 1'b0)});
            for (int k = 1; k <= COL; k++) q.push_back('{2'd0, word(8'h48, k - 1, 0, 1'b0)});
            q.push_back('{2'd0, word(8'h40, 0, 0, 1'b0)});
        end
        for (int i = 0; i < TC; i++) q.push_back('{2'd1, word(8'h10, i, 0, 1'b0)});
        for (int i = 0; i < TC; i++) q.push_back('{2'd0, word(8'hA0, i, 0, 1'b0)});
        for (int i = 0; i < DR; i++) q.push_back('{2'd0, 21'd0});
        for (int i = 0; i < TC; i++) q.push_back('{2'd0, word(8'h01, 0, i, 1'b1)});
        if (ro) for (int i = 0; i < TC; i++) q.push_back('{2'd0, word(8'h02, 0, i, 1'b0)});
        q.push_back('{2'd3, 21'd0});
    endtask
    task automatic model(input logic rst, input logic st, input logic ln, input logic ro, input logic iv,
                         input logic [PR*BW-1:0] d);
        slot_t s;
        if (rst) begin
            q.delete();
            e_inst = '0; e_mem = '0; e_ov = 1'b0; e_done = 1'b0;
        end else begin
            e_ov = e_inst[1];
            e_done = 1'b0;
            if (q.size() == 0) begin
                e_inst = '0;
                if (st) build(ln, ro);
            end else begin
                s = q[0];
                if (s.kind == 2'd3) begin
                    e_inst = '0; e_done = 1'b1; s = q.pop_front();
                end else if (s.kind == 2'd0) begin
                    e_inst = s.w; s = q.pop_front();
                end else if (iv) begin
                    e_inst = s.w; e_mem = d; s = q.pop_front();
                end else e_inst = {5'b0, e_inst[15:12], 12'b0};
            end
        end
        e_busy = q.size() != 0;
        e_rdy = e_busy && q[0].kind == 2'd1;
    endtask
    task automatic step(input logic rst, input logic st, input logic ln, input logic ro, input logic iv);
        reset = rst; start = st; load_n = ln; read_out = ro; in_valid = iv;
        in_data = {$urandom, $urandom};
        @(posedge clk);
        #1;
        model(rst, st, ln, ro, iv, in_data);
        cyc++;
    endtask
    function automatic logic ivf(input int mode);
        return mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
    endfunction
    task automatic run_seq(input logic ln, input logic ro, input int mode, input int poke);
        step(1'b0, 1'b1, ln, ro, ivf(mode));
        len = 0; ovc = 0; first = '0;
        while (done !== 1'b1 && len < 400) begin
            step(1'b0, len == poke, ln, ro, ivf(mode));
            len++;
            ovc += int'(out_valid);
            if (first == 0) first = inst;
        end
        if (len >= 400) chk("timeout", 64'(done), 64'(1));
    endtask
    always @(negedge clk) if (live) begin
        chk("inst", 64'(inst), 64'(e_inst));
        chk("mem_in", 64'(mem_in), 64'(e_mem));
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        chk("done", 64'(done), 64'(e_done));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("in_ready", 64'(in_ready), 64'(e_rdy));
    end
    initial begin
        int w;
        live = 1'b1;
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_inst", 64'(inst), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        run_seq(1'b1, 1'b1, 0, -1);
        chk("full_len", 64'(len), 64'(61));
        chk("full_ov", 64'(ovc), 64'(8));
        chk("full_first", 64'(first), 64'(21'h4));
        run_seq(1'b1, 1'b1, 1, -1);
        chk("stall_ov", 64'(ovc), 64'(8));
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq(1'b0, 1'b0, 0, -1);
        chk("reuse_len", 64'(len), 64'(35));
        chk("reuse_first", 64'(first), 64'(21'h10));
        chk("reuse_ov", 64'(ovc), 64'(0));
        run_seq(1'b1, 1'b1, 0, -1);
        chk("b2b_len", 64'(len), 64'(61));
        chk("b2b_first", 64'(first), 64'(21'h4));
        run_seq(1'b1, 1'b1, 0, 37);
        chk("busy_start_len", 64'(len), 64'(61));
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        w = 0;
        while (!(inst[7] && inst[15:12] == 4'd3) && w < 200) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            w++;
        end
        if (w >= 200) chk("exe3_timeout", 64'(w), 64'(0));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_inst", 64'(inst), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_rdy", 64'(in_ready), 64'(0));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq(1'b1, 1'b1, 0, -1);
        chk("after_rst_len", 64'(len), 64'(61));
        chk("after_rst_first", 64'(first), 64'(21'h4));
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom_range(0, 1)) & 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            run_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, int'($urandom_range(0, 60)));
        end
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        live = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
